// File: rtl/pa_perips_timer_sched.sv
// pa_perips_timer_sched: multi-channel down-counting alarm timer with round-robin expiry event dispatch
module pa_perips_timer_sched #(
    parameter int CH_NUM = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  addr_i,
    input  logic        data_rd_i,
    input  logic        data_we_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        evt_valid_o,
    output logic [2:0]  evt_id_o,
    input  logic        evt_ready_i,
    output logic        irq_o
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t state;
    logic ctrl_en;
    logic [31:0] psc, psc_cnt, rdata;
    logic [31:0] load [CH_NUM];
    logic [31:0] count [CH_NUM];
    logic [CH_NUM-1:0] pend, ovr, ch_en, ch_os, expire, pend_clr, pend_n, ovr_n, rot;
    logic [2:0] ptr, pick, ptr_inc;
    logic [3:0] ch_idx;
    logic tick, accept, ch_hit;

    assign tick = ctrl_en && psc_cnt == psc;
    assign accept = state == OFFER && evt_ready_i;
    assign ch_hit = addr_i[7:4] != 4'd0 && int'(addr_i[7:4]) <= CH_NUM && addr_i[1:0] == 2'b00;
    assign ch_idx = addr_i[7:4] - 4'd1;
    assign ptr_inc = (int'(evt_id_o) == CH_NUM - 1) ? 3'd0 : evt_id_o + 3'd1;
    // Rotating PEND by ptr turns the wrapped search into a plain lowest-bit search
    assign rot = CH_NUM'({pend, pend} >> ptr);

    always_comb begin
        pick = ptr;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (rot[i]) pick = 3'((int'(ptr) + i) % CH_NUM);
    end

    // Expiry wins over any clear landing in the same cycle
    always_comb begin
        expire = '0;
        pend_clr = (data_we_i && addr_i == 8'h08) ? data_i[CH_NUM-1:0] : '0;
        for (int k = 0; k < CH_NUM; k++) begin
            expire[k] = tick && ch_en[k] && count[k] == 32'd0;
            if (accept && int'(evt_id_o) == k) pend_clr[k] = 1'b1;
        end
        pend_n = (pend & ~pend_clr) | expire;
        ovr_n = (ovr & ~((data_we_i && addr_i == 8'h0C) ? data_i[CH_NUM-1:0] : '0)) | (expire & pend & ~pend_clr);
    end

    always_comb begin
        rdata = '0;
        if (addr_i == 8'h00) rdata[0] = ctrl_en;
        if (addr_i == 8'h04) rdata = psc;
        if (addr_i == 8'h08) rdata[CH_NUM-1:0] = pend;
        if (addr_i == 8'h0C) rdata[CH_NUM-1:0] = ovr;
        for (int k = 0; k < CH_NUM; k++)
            if (ch_hit && int'(ch_idx) == k)
                rdata = addr_i[3:2] == 2'd0 ? {30'd0, ch_os[k], ch_en[k]} :
                        addr_i[3:2] == 2'd1 ? load[k] :
                        addr_i[3:2] == 2'd2 ? count[k] : 32'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en <= 1'b0;
            psc <= '0;
            psc_cnt <= '0;
            pend <= '0;
            ovr <= '0;
            ch_en <= '0;
            ch_os <= '0;
            ptr <= '0;
            state <= IDLE;
            evt_valid_o <= 1'b0;
            evt_id_o <= '0;
            irq_o <= 1'b0;
            data_o <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                load[k] <= '0;
                count[k] <= '0;
            end
        end else begin
            psc_cnt <= (!ctrl_en || tick) ? '0 : psc_cnt + 32'd1;
            pend <= pend_n;
            ovr <= ovr_n;
            irq_o <= |pend_n;
            if (data_rd_i) data_o <= rdata;
            if (data_we_i && addr_i == 8'h00) ctrl_en <= data_i[0];
            if (data_we_i && addr_i == 8'h04) psc <= data_i;
            for (int k = 0; k < CH_NUM; k++) begin
                count[k] <= (!ctrl_en || !ch_en[k] || expire[k]) ? load[k] : count[k] - 32'(tick);
                if (expire[k] && ch_os[k]) ch_en[k] <= 1'b0;
                if (data_we_i && ch_hit && int'(ch_idx) == k && addr_i[3:2] == 2'd0) begin
                    ch_en[k] <= data_i[0];
                    ch_os[k] <= data_i[1];
                end
                if (data_we_i && ch_hit && int'(ch_idx) == k && addr_i[3:2] == 2'd1) load[k] <= data_i;
            end
            if (state == IDLE) begin
                if (pend != '0) begin
                    evt_id_o <= pick;
                    evt_valid_o <= 1'b1;
                    state <= OFFER;
                end
            end else if (evt_ready_i) begin
                ptr <= ptr_inc;
                evt_valid_o <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule
